// File: rtl/multi_debounce.sv
// multi_debounce: multi-channel button debouncer with shared sample tick and auto-repeat
// Ports:
//    clk, reset          - clock, asynchronous active-high reset
//    button_in[N_CH]     - raw asynchronous button levels (inverted first when ACTIVE_LOW)
//    repeat_en[N_CH]     - per-channel auto-repeat enable
//    db_out[N_CH]        - debounced level, 1 = pressed
//    press_pulse[N_CH]   - one-cycle pulse on accepted press
//    release_pulse[N_CH] - one-cycle pulse on accepted release
//    repeat_pulse[N_CH]  - one-cycle pulse per auto-repeat event
//    tick                - one-cycle sample strobe
module multi_debounce #(
   parameter int N_CH         = 4,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 20,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] button_in,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] repeat_pulse,
   output logic            tick
);
   localparam int PW   = $clog2(TICK_DIV);
   localparam int SW   = $clog2(STABLE_TICKS + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [1:0] RELEASED     = 2'b00;
   localparam logic [1:0] PRESS_WAIT   = 2'b01;
   localparam logic [1:0] PRESSED      = 2'b10;
   localparam logic [1:0] RELEASE_WAIT = 2'b11;

   logic [PW-1:0]   div_q, div_d;
   logic            tick_q, tick_d;
   logic [N_CH-1:0] s1_q, s1_d, s2_q;

   always_comb begin
      div_d  = (div_q == PW'(TICK_DIV - 1)) ? '0 : div_q + PW'(1);
      tick_d = div_q == PW'(TICK_DIV - 1);
      s1_d   = (ACTIVE_LOW != 0) ? ~button_in : button_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
         s1_q   <= s1_d;
         s2_q   <= s1_q;
      end
   end

   assign tick = tick_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [1:0]    st_q, st_d;
      logic [SW-1:0] cnt_q, cnt_d, cnt_nx;
      logic [RW-1:0] rc_q, rc_d, lim;
      logic          ph_q, ph_d, db_q, db_d, pp_q, pp_d, rl_q, rl_d, rp_q, rp_d;
      logic          held, waiting, cand, done;

      always_comb begin
         held    = st_q == PRESSED || st_q == RELEASE_WAIT;
         waiting = st_q == PRESS_WAIT || st_q == RELEASE_WAIT;
         // a sample disagreeing with the accepted level is a candidate for a change
         cand    = s2_q[c] != held;
         cnt_nx  = waiting ? cnt_q + SW'(1) : SW'(1);
         done    = cand && cnt_nx == SW'(STABLE_TICKS);
         st_d    = st_q;
         cnt_d   = cnt_q;
         if (tick_q) begin
            st_d  = !cand ? (held ? PRESSED : RELEASED)
                  : done  ? (held ? RELEASED : PRESSED)
                  :         (held ? RELEASE_WAIT : PRESS_WAIT);
            cnt_d = (cand && !done) ? cnt_nx : '0;
         end
         pp_d = tick_q && done && !held;
         rl_d = tick_q && done && held;
         // ph_q selects the first-repeat delay (0) or the steady repeat rate (1)
         lim  = ph_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
         rc_d = rc_q;
         ph_d = ph_q;
         rp_d = 1'b0;
         if (!held || !repeat_en[c] || rl_d) begin
            rc_d = '0;
            ph_d = 1'b0;
         end else if (tick_q) begin
            rp_d = rc_q + RW'(1) == lim;
            rc_d = rp_d ? '0 : rc_q + RW'(1);
            ph_d = ph_q || rp_d;
         end
         db_d = st_d == PRESSED || st_d == RELEASE_WAIT;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st_q  <= RELEASED;
            cnt_q <= '0;
            rc_q  <= '0;
            ph_q  <= 1'b0;
            db_q  <= 1'b0;
            pp_q  <= 1'b0;
            rl_q  <= 1'b0;
            rp_q  <= 1'b0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            rc_q  <= rc_d;
            ph_q  <= ph_d;
            db_q  <= db_d;
            pp_q  <= pp_d;
            rl_q  <= rl_d;
            rp_q  <= rp_d;
         end
      end

      assign db_out[c]        = db_q;
      assign press_pulse[c]   = pp_q;
      assign release_pulse[c] = rl_q;
      assign repeat_pulse[c]  = rp_q;
   end
endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: directed and random checks of multi_debounce against a sample-window model
// Ports: none (top-level bench); drives an active-high and an active-low instance in lockstep
module tb_multi_debounce;
   localparam int NC = 2;
   localparam int TD = 4;
   localparam int ST = 3;
   localparam int RD = 5;
   localparam int RR = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] bi = '0;
   logic [1:0] en = '0;
   logic [1:0] db, pp, rl, rp, db_a, pp_a, rl_a, rp_a;
   logic tk, tk_a;
   logic [1:0] bi_n;

   int n_vec = 0;
   int n_bad = 0;
   int cyc_n = 0;

   int k;
   logic [1:0] inq[$];
   logic [1:0] shist[$];
   logic [1:0] lvl, e_p, e_r, e_rep;
   logic x_tk;
   int since[2];

   int n_press[2], n_rel[2], t_pr[2];
   int t_rep[$];
   bit aft_rel;
   int n_rep_aft;

   always #5 clk = ~clk;
   assign bi_n = ~bi;

   multi_debounce #(.N_CH(NC), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD),
                    .REPEAT_RATE(RR), .ACTIVE_LOW(0)) dut (
      .clk(clk), .reset(reset), .button_in(bi), .repeat_en(en), .db_out(db),
      .press_pulse(pp), .release_pulse(rl), .repeat_pulse(rp), .tick(tk));

   multi_debounce #(.N_CH(NC), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD),
                    .REPEAT_RATE(RR), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .reset(reset), .button_in(bi_n), .repeat_en(en), .db_out(db_a),
      .press_pulse(pp_a), .release_pulse(rl_a), .repeat_pulse(rp_a), .tick(tk_a));

   function automatic void model_reset();
      k = 0;
      inq.delete();
      shist.delete();
      lvl = '0;
      e_p = '0;
      e_r = '0;
      e_rep = '0;
      x_tk = 1'b0;
      since[0] = 0;
      since[1] = 0;
   endfunction

   // One clock edge: a level change is accepted once the last ST tick samples
   // all disagree with the accepted level; samples lag the pin by two edges.
   function automatic void model_edge();
      logic tk_now, all_d;
      logic [1:0] s, lvl0, h;
      tk_now = k > 0 && k % TD == 0;
      s = inq.size() >= 2 ? inq[inq.size() - 2] : 2'b00;
      lvl0 = lvl;
      e_p = '0;
      e_r = '0;
      e_rep = '0;
      if (tk_now) begin
         shist.push_back(s);
         for (int c = 0; c < NC; c++) begin
            if (shist.size() >= ST) begin
               all_d = 1'b1;
               for (int j = 1; j <= ST; j++) begin
                  h = shist[shist.size() - j];
                  if (h[c] == lvl0[c]) all_d = 1'b0;
               end
               if (all_d) begin
                  lvl[c] = ~lvl0[c];
                  if (lvl0[c]) e_r[c] = 1'b1;
                  else e_p[c] = 1'b1;
               end
            end
         end
      end
      for (int c = 0; c < NC; c++) begin
         if (!lvl0[c] || !en[c] || e_r[c]) since[c] = 0;
         else if (tk_now) begin
            since[c]++;
            e_rep[c] = since[c] == RD || (since[c] > RD && (since[c] - RD) % RR == 0);
         end
      end
      inq.push_back(bi);
      k++;
      x_tk = k % TD == 0;
   endfunction

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_press = '{0, 0};
      n_rel = '{0, 0};
      t_pr = '{-1, -1};
      t_rep.delete();
      aft_rel = 1'b0;
      n_rep_aft = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc_n++;
      chk("db_out", db, lvl);
      chk("press_pulse", pp, e_p);
      chk("release_pulse", rl, e_r);
      chk("repeat_pulse", rp, e_rep);
      chk("tick", {1'b0, tk}, {1'b0, x_tk});
      chk("al_db_out", db_a, lvl);
      chk("al_press_pulse", pp_a, e_p);
      chk("al_release_pulse", rl_a, e_r);
      chk("al_repeat_pulse", rp_a, e_rep);
      chk("al_tick", {1'b0, tk_a}, {1'b0, x_tk});
      for (int c = 0; c < NC; c++) begin
         if (pp[c]) begin
            n_press[c]++;
            t_pr[c] = cyc_n;
         end
         if (rl[c]) n_rel[c]++;
      end
      if (rp[1]) begin
         t_rep.push_back(cyc_n);
         if (aft_rel) n_rep_aft++;
      end
      if (rl[1]) aft_rel = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_db_out", db, 2'b00);
      chk("rst_press", pp, 2'b00);
      chk("rst_release", rl, 2'b00);
      chk("rst_repeat", rp, 2'b00);
      chk("rst_tick", {1'b0, tk}, 2'b00);
      chk("rst_al_db_out", db_a, 2'b00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc_n = 0;
   endtask

   initial begin
      model_reset();
      clr();
      do_reset();
      run(16);
      clr();
      bi = 2'b01;
      run(24);
      chk_i("hold_press_count", n_press[0], 1);
      bi = 2'b00;
      run(24);
      chk_i("hold_release_count", n_rel[0], 1);
      clr();
      bi = 2'b01;
      run(8);
      bi = 2'b00;
      run(24);
      chk_i("glitch_press_count", n_press[0], 0);
      clr();
      en = 2'b10;
      bi = 2'b10;
      run(64);
      chk_i("rep_press_count", n_press[1], 1);
      chk_i("rep_gap1", t_rep.size() > 0 ? t_rep[0] - t_pr[1] : -1, RD * TD);
      chk_i("rep_gap2", t_rep.size() > 1 ? t_rep[1] - t_pr[1] : -1, (RD + RR) * TD);
      chk_i("rep_gap3", t_rep.size() > 2 ? t_rep[2] - t_pr[1] : -1, (RD + 2 * RR) * TD);
      bi = 2'b00;
      run(40);
      chk_i("rep_release_count", n_rel[1], 1);
      chk_i("rep_after_release", n_rep_aft, 0);
      en = 2'b00;
      bi = 2'b01;
      run(6);
      do_reset();
      clr();
      run(24);
      chk_i("rst_held_press_count", n_press[0], 1);
      chk_i("rst_held_press_cycle", t_pr[0], 13);
      chk_i("rst_held_no_release", n_rel[0], 0);
      bi = 2'b00;
      run(24);
      for (int i = 0; i < 2500; i++) begin
         for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 23) == 0) bi[c] = ~bi[c];
         if ($urandom_range(0, 59) == 0) en = 2'($urandom);
         if ($urandom_range(0, 699) == 0) do_reset();
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
